// File: rtl/simmem_resp_bank_if.sv
// Bus bundle for the response bank: the input handshake from the memory side,
// the release interface with the delay bank, and the registered output stage.
interface simmem_resp_bank_if #(
  parameter int TotalCapacity = 64,
  parameter int DataWidth     = 16
);
  localparam int AddrWidth = $clog2(TotalCapacity);

  logic [DataWidth-1:0]     data_i;
  logic                     in_valid_i;
  logic                     in_ready_o;
  logic [AddrWidth-1:0]     address_o;
  logic [TotalCapacity-1:0] release_en_i;
  logic [TotalCapacity-1:0] address_released_onehot_o;
  logic [DataWidth-1:0]     data_o;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic [AddrWidth:0]       occupancy_o;

  modport slave (
    input  data_i, in_valid_i, release_en_i, out_ready_i,
    output in_ready_o, address_o, address_released_onehot_o,
           data_o, out_valid_o, occupancy_o
  );

  modport master (
    output data_i, in_valid_i, release_en_i, out_ready_i,
    input  in_ready_o, address_o, address_released_onehot_o,
           data_o, out_valid_o, occupancy_o
  );
endinterface

// File: rtl/simmem_resp_bank.sv
// Response storage bank: responses land in the lowest free slot, wait there
// until the delay bank enables their release, then drain in lowest-index order
// through a single registered output stage.
module simmem_resp_bank #(
  parameter int TotalCapacity = 64,
  parameter int DataWidth     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  simmem_resp_bank_if.slave    bus
);
  localparam int AddrWidth = $clog2(TotalCapacity);

  logic [DataWidth-1:0]     r_mem [TotalCapacity];
  logic [TotalCapacity-1:0] r_valid;
  logic [DataWidth-1:0]     r_data;
  logic                     r_out_valid;
  logic [AddrWidth:0]       r_occ;

  logic [AddrWidth-1:0]     w_free_idx;
  logic                     w_has_free;
  logic [TotalCapacity-1:0] w_eligible;
  logic [AddrWidth-1:0]     w_sel_idx;
  logic                     w_load_en;
  logic                     w_in_fire;
  logic [TotalCapacity-1:0] w_released;

  // Lowest free slot, taken from registered valid bits only.
  always_comb begin
    w_free_idx = '0;
    for (int i = TotalCapacity - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_free_idx = AddrWidth'(i);
    end
  end

  // Lowest eligible slot; release enables on empty slots are masked out.
  always_comb begin
    w_sel_idx = '0;
    for (int i = TotalCapacity - 1; i >= 0; i--) begin
      if (w_eligible[i]) w_sel_idx = AddrWidth'(i);
    end
  end

  assign w_has_free = ~&r_valid;
  assign w_eligible = r_valid & bus.release_en_i;
  assign w_load_en  = (!r_out_valid || bus.out_ready_i) && (|w_eligible);
  assign w_in_fire  = bus.in_valid_i && w_has_free;
  assign w_released = w_load_en ? (TotalCapacity'(1) << w_sel_idx) : '0;

  // Slot storage; contents are only meaningful under the valid bit.
  always_ff @(posedge clk_i) begin
    if (w_in_fire) r_mem[w_free_idx] <= bus.data_i;
  end

  // Slot valid bits: set on reserve, cleared on load (never the same slot).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= '0;
    end else begin
      if (w_in_fire) r_valid[w_free_idx] <= 1'b1;
      if (w_load_en) r_valid[w_sel_idx]  <= 1'b0;
    end
  end

  // Output register: load on free/draining stage, else drop valid when taken.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data      <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load_en) begin
      r_data      <= r_mem[w_sel_idx];
      r_out_valid <= 1'b1;
    end else if (bus.out_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  // Occupancy counts stored slots only, not the output register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_occ <= '0;
    end else begin
      case ({w_in_fire, w_load_en})
        2'b10:   r_occ <= r_occ + (AddrWidth+1)'(1);
        2'b01:   r_occ <= r_occ - (AddrWidth+1)'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign bus.in_ready_o                = w_has_free;
  assign bus.address_o                 = w_free_idx;
  assign bus.address_released_onehot_o = w_released;
  assign bus.data_o                    = r_data;
  assign bus.out_valid_o               = r_out_valid;
  assign bus.occupancy_o               = r_occ;

  a_rel_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(w_released));
  a_rel_valid: assert property (@(posedge clk_i) disable iff (rst_i)
    ((w_released & ~r_valid) == '0));
  a_hold_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (r_out_valid && !bus.out_ready_i) |=> $stable(r_data));
  a_no_overwrite: assert property (@(posedge clk_i) disable iff (rst_i)
    w_in_fire |-> !r_valid[w_free_idx]);
endmodule

// File: tb/tb_simmem_resp_bank.sv
// Bench for simmem_resp_bank: directed stimulus with a data scoreboard.
// The stimulus pushes the expected output data when it triggers a release;
// the monitor pops and compares on every output transfer.
module tb_simmem_resp_bank;
  localparam int TC = 64;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  simmem_resp_bank_if #(.TotalCapacity(TC), .DataWidth(DW)) bus ();

  simmem_resp_bank #(.TotalCapacity(TC), .DataWidth(DW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid_i   = 1'b0;
    bus.release_en_i = '0;
    cyc();
    rst = 1'b0;
  endtask

  // Monitor: every transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.out_valid_o && bus.out_ready_i) begin
      if (exp_q.size() == 0) begin
        check("spurious_output", 64'(bus.data_o), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("out_data", 64'(bus.data_o), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    bus.data_i       = '0;
    bus.in_valid_i   = 1'b0;
    bus.release_en_i = '0;
    bus.out_ready_i  = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;

    // Reset then idle
    mid();
    check("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
    check("rst_address", 64'(bus.address_o), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    check("rst_occupancy", 64'(bus.occupancy_o), 64'd0);
    check("rst_released", bus.address_released_onehot_o, 64'd0);

    // Single response, minimum latency
    cyc();
    bus.out_ready_i = 1'b1;
    bus.data_i      = 16'hA5A5;
    bus.in_valid_i  = 1'b1;
    mid();
    check("single_addr", 64'(bus.address_o), 64'd0);
    cyc();
    bus.in_valid_i   = 1'b0;
    bus.release_en_i = 64'h1;
    exp_q.push_back(16'hA5A5);
    mid();
    check("single_rel_pulse", bus.address_released_onehot_o, 64'h1);
    check("single_occ1", 64'(bus.occupancy_o), 64'd1);
    check("single_no_early_valid", 64'(bus.out_valid_o), 64'd0);
    cyc();
    bus.release_en_i = '0;
    mid();
    check("single_out_valid", 64'(bus.out_valid_o), 64'd1);
    check("single_occ0", 64'(bus.occupancy_o), 64'd0);
    check("single_rel_clear", bus.address_released_onehot_o, 64'd0);
    cyc();
    mid();
    check("single_valid_drop", 64'(bus.out_valid_o), 64'd0);

    // Fill every slot
    cyc();
    for (int i = 0; i < TC; i++) begin
      bus.data_i     = 16'(i);
      bus.in_valid_i = 1'b1;
      mid();
      check("fill_addr", 64'(bus.address_o), 64'(i));
      check("fill_ready", 64'(bus.in_ready_o), 64'd1);
      cyc();
    end
    bus.data_i = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      mid();
      check("full_ready", 64'(bus.in_ready_o), 64'd0);
      check("full_occ", 64'(bus.occupancy_o), 64'd64);
      cyc();
    end
    bus.in_valid_i   = 1'b0;
    bus.release_en_i = 64'h1 << 5;
    exp_q.push_back(16'd5);
    mid();
    check("full_rel5_pulse", bus.address_released_onehot_o, 64'h20);
    check("full_rel5_ready_still0", 64'(bus.in_ready_o), 64'd0);
    cyc();
    bus.release_en_i = '0;
    mid();
    check("reuse_addr5", 64'(bus.address_o), 64'd5);
    check("reuse_ready", 64'(bus.in_ready_o), 64'd1);
    check("reuse_occ", 64'(bus.occupancy_o), 64'd63);
    cyc();
    do_reset();

    // Stalled output with sparse release enables
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.data_i     = 16'(i);
      bus.in_valid_i = 1'b1;
      cyc();
    end
    bus.in_valid_i   = 1'b0;
    bus.release_en_i = 64'b1010;
    exp_q.push_back(16'd1);
    mid();
    check("stall_first_pulse", bus.address_released_onehot_o, 64'h2);
    cyc();
    for (int i = 0; i < 2; i++) begin
      mid();
      check("stall_valid", 64'(bus.out_valid_o), 64'd1);
      check("stall_data_held", 64'(bus.data_o), 64'd1);
      check("stall_no_pulse", bus.address_released_onehot_o, 64'd0);
      cyc();
    end
    bus.out_ready_i = 1'b1;
    exp_q.push_back(16'd3);
    mid();
    check("unstall_pulse3", bus.address_released_onehot_o, 64'h8);
    cyc();
    mid();
    check("unstall_data3", 64'(bus.data_o), 64'd3);
    check("unstall_no_more", bus.address_released_onehot_o, 64'd0);
    cyc();
    mid();
    check("unstall_valid_drop", 64'(bus.out_valid_o), 64'd0);
    check("unstall_occ", 64'(bus.occupancy_o), 64'd2);
    cyc();
    do_reset();

    // Only slot 2 valid, all release enables set
    for (int i = 0; i < 3; i++) begin
      bus.data_i     = 16'h100 + 16'(i);
      bus.in_valid_i = 1'b1;
      cyc();
    end
    bus.in_valid_i   = 1'b0;
    bus.release_en_i = 64'h3;
    exp_q.push_back(16'h100);
    exp_q.push_back(16'h101);
    mid();
    check("pre_drain_pulse0", bus.address_released_onehot_o, 64'h1);
    cyc();
    mid();
    check("pre_drain_pulse1", bus.address_released_onehot_o, 64'h2);
    cyc();
    bus.release_en_i = '0;
    cyc();
    bus.release_en_i = '1;
    exp_q.push_back(16'h102);
    mid();
    check("allones_pulse", bus.address_released_onehot_o, 64'h4);
    cyc();
    mid();
    check("allones_out_data", 64'(bus.data_o), 64'h102);
    check("allones_no_second", bus.address_released_onehot_o, 64'd0);
    cyc();
    mid();
    check("allones_idle", 64'(bus.out_valid_o), 64'd0);
    check("allones_occ", 64'(bus.occupancy_o), 64'd0);
    bus.release_en_i = '0;
    cyc();
    do_reset();

    // Reset with stored data and a loaded output register
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.data_i     = 16'h200 + 16'(i);
      bus.in_valid_i = 1'b1;
      cyc();
    end
    bus.in_valid_i   = 1'b0;
    bus.release_en_i = 64'h1;
    cyc();
    mid();
    check("prerst_out_valid", 64'(bus.out_valid_o), 64'd1);
    check("prerst_occ", 64'(bus.occupancy_o), 64'd9);
    cyc();
    rst = 1'b1;
    bus.in_valid_i   = 1'b1;
    bus.release_en_i = '1;
    cyc();
    rst = 1'b0;
    bus.in_valid_i   = 1'b0;
    bus.release_en_i = '0;
    mid();
    check("postrst_out_valid", 64'(bus.out_valid_o), 64'd0);
    check("postrst_data", 64'(bus.data_o), 64'd0);
    check("postrst_occ", 64'(bus.occupancy_o), 64'd0);
    check("postrst_addr", 64'(bus.address_o), 64'd0);
    check("postrst_ready", 64'(bus.in_ready_o), 64'd1);
    check("postrst_released", bus.address_released_onehot_o, 64'd0);

    cyc();
    cyc();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/simmem_resp_bank.md
Name: simmem_resp_bank

Overview:
- Response storage bank for the simulated memory controller; one instance for write responses, one for read data.
- Accepts responses from the real memory side into a free slot and reports the slot index as the local identifier for the delay bank.
- Holds each response until the delay bank raises the slot's release-enable bit, then drains it through a registered valid/ready output stage.
- Reports every drained slot back to the delay bank as a one-hot released pulse.

Parameters:
- TotalCapacity, 64, number of response slots; power of two, at least 2.
- DataWidth, 16, width of one stored response (ID and payload packed).
- AddrWidth, $clog2(TotalCapacity), localparam, width of a slot index.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset, synchronous, active-high.
- data_i  input  DataWidth  incoming response.
- in_valid_i  input  1  incoming response valid.
- in_ready_o  output  1  a free slot exists.
- address_o  output  AddrWidth  slot index that the current input handshake will occupy; meaningful only while in_ready_o=1.
- release_en_i  input  TotalCapacity  per-slot release enable from the delay bank.
- address_released_onehot_o  output  TotalCapacity  one-hot pulse marking the slot drained this cycle.
- data_o  output  DataWidth  output response.
- out_valid_o  output  1  output valid.
- out_ready_i  input  1  downstream ready.
- occupancy_o  output  AddrWidth+1  number of occupied slots; excludes the output register.

Behaviour:
- Reset: synchronous on posedge clk_i while rst_i=1. All slot valid bits are cleared. Reset values: out_valid_o=0, data_o=0, occupancy_o=0, address_released_onehot_o=0, in_ready_o=1, address_o=0. Reset overrides every concurrent event; in-flight data is discarded.
- Free-slot selection: address_o is the lowest-index slot whose registered valid bit is 0. in_ready_o = OR of the inverted valid bits. Both are combinational from registers only, with no dependence on in_valid_i.
- Input handshake (in_valid_i & in_ready_o):
  - data_i is written to slot address_o.
  - The slot's valid bit is set at the next edge.
  - If in_valid_i=1 with in_ready_o=0, nothing is written; the source must hold its data.
- Eligibility: a slot is eligible when valid_q=1 and release_en_i[slot]=1. A release_en_i bit on an invalid slot is ignored.
- Output stage: a single register holding data_o and out_valid_o.
  - load_en = (!out_valid_o | out_ready_i) & (any slot eligible).
  - On load_en, the lowest-index eligible slot is selected. Its data goes to data_o and out_valid_o=1 at the next edge, and its valid bit clears at the next edge.
  - address_released_onehot_o = one-hot of the selected slot when load_en=1, otherwise 0. This is combinational in the load cycle, so the delay bank can clear its release-enable bit at the same edge.
  - If out_valid_o=1, out_ready_i=1 and nothing is eligible, out_valid_o goes to 0 at the next edge.
  - While out_valid_o=1 and out_ready_i=0: data_o is held stable, no load occurs and address_released_onehot_o=0.
  - Throughput is one response per cycle under continuous out_ready_i.
- Latency: a response accepted at edge T with release_en set during cycle T+1 is loaded at edge T+2 (out_valid_o=1 from cycle T+2). Minimum storage-to-output latency is 2 cycles.
- Slot reuse: a slot freed by a load is not offered on address_o until the following cycle, because selection uses registered valid bits. A drained slot and a newly reserved slot are therefore never the same index in the same cycle.
- Simultaneous reserve and drain: when full, in_ready_o=0 even if a load occurs in the same cycle. No bypass from input to output.
- Occupancy: +1 on input handshake, -1 on load, unchanged when both or neither occur. It never exceeds TotalCapacity and never underflows. occupancy_o = TotalCapacity exactly when in_ready_o=0.
- Assertions (verification):
  - address_released_onehot_o is $onehot0.
  - A released slot was valid the same cycle.
  - data_o is stable while out_valid_o & !out_ready_i.
  - No write to a valid slot.

Test Plan:
- Reset then idle: in_ready_o=1, address_o=0, out_valid_o=0, occupancy_o=0, address_released_onehot_o=0.
- Write data_i=16'hA5A5 at edge T (address_o=0), set release_en_i[0]=1 in cycle T+1, out_ready_i=1 -> address_released_onehot_o=64'h1 in cycle T+1; data_o=16'hA5A5 with out_valid_o=1 from cycle T+2; occupancy_o 1 then 0.
- Fill 64 slots with data_i=index -> address_o steps 0..63; then in_ready_o=0 and occupancy_o=64. Hold in_valid_i=1 for 3 cycles -> no write. Release slot 5 -> slot 5 drained; the next cycle address_o=5 and in_ready_o=1.
- Fill slots 0..3, assert release_en_i=4'b1010 with out_ready_i=0 -> slot 1 loaded first, then stalled: data_o=1 held, address_released_onehot_o=0 while stalled. Raise out_ready_i -> slot 3 is next and releases pulse 4'b1000; out_valid_o drops after slot 3 is consumed.
- release_en_i=all ones while only slot 2 is valid -> exactly one pulse, 64'h4; no spurious output.
- Assert rst_i while 10 slots are valid and out_valid_o=1 -> next cycle all outputs at reset values, occupancy_o=0, address_o=0.
